// File: rtl/tf_gen_ctrl_pkg.sv
// tf_gen_ctrl_pkg: shared state encoding, command-strobe bundle and counter width
package tf_gen_ctrl_pkg;
  localparam int UPD_CNT_W = 16;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LD_CONST = 3'd1,
    S_LD_BASE  = 3'd2,
    S_RDY      = 3'd3,
    S_RD       = 3'd4,
    S_WAIT     = 3'd5,
    S_WR       = 3'd6
  } tf_ctrl_state_e;
  typedef struct packed {
    logic init_const;
    logic init_base;
    logic ren;
    logic wen;
  } tf_cmd_t;
endpackage

// File: rtl/tf_sat_cnt.sv
// tf_sat_cnt: generic saturating up-counter with synchronous clear
module tf_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/tf_gen_ctrl.sv
// tf_gen_ctrl: TF_gen bank-load and twiddle-update sequencer
// TF_GEN_CTRL_PERF_EN adds the saturating upd_cnt output
`ifndef D_width
`define D_width 3
`endif
module tf_gen_ctrl
  import tf_gen_ctrl_pkg::*;
#(
  parameter int IT_DEPTH = 3,
  parameter int MUL_LAT  = 3,
  parameter int D_WIDTH  = `D_width
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               const_vld,
  output logic               const_rdy,
  input  logic               base_vld,
  output logic               base_rdy,
  output logic               init_done,
  input  logic               upd_req,
  input  logic [D_WIDTH-1:0] upd_depth,
  output logic               upd_ack,
  output logic               tf_valid,
  output logic               err_depth,
  output logic               busy,
  output logic               TF_init_const,
  output logic               TF_init_base,
  output logic               TF_ren,
  output logic               TF_wen,
`ifdef TF_GEN_CTRL_PERF_EN
  output logic [D_WIDTH-1:0] it_depth_cnt,
  output logic [UPD_CNT_W-1:0] upd_cnt
`else
  output logic [D_WIDTH-1:0] it_depth_cnt
`endif
);
  localparam int WC_W = $clog2(MUL_LAT) + 1;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MUL_LAT - 2);
  tf_ctrl_state_e state, state_nxt;
  logic [WC_W-1:0] wcnt;
  logic ren_q, wen_q;
  logic depth_ok, last_base, ld_const, ld_base, req_rdy, acc, err;
  tf_cmd_t cmd;
  assign const_rdy = state == S_LD_CONST;
  assign base_rdy  = state == S_LD_BASE;
  assign ld_const  = const_rdy && const_vld;
  assign ld_base   = base_rdy && base_vld;
  assign depth_ok  = 32'(upd_depth) < IT_DEPTH;
  assign last_base = it_depth_cnt == D_WIDTH'(IT_DEPTH - 1);
  // start outranks a simultaneous request, so a reload never issues a read
  assign req_rdy   = state == S_RDY && !start && upd_req;
  assign acc       = req_rdy && depth_ok;
  assign err       = req_rdy && !depth_ok;
  assign cmd = '{init_const: ld_const, init_base: ld_base, ren: ren_q, wen: wen_q};
  assign TF_init_const = cmd.init_const;
  assign TF_init_base  = cmd.init_base;
  assign TF_ren        = cmd.ren;
  assign TF_wen        = cmd.wen;
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     state_nxt = start ? S_LD_CONST : S_IDLE;
      S_LD_CONST: state_nxt = const_vld ? S_LD_BASE : S_LD_CONST;
      S_LD_BASE:  state_nxt = (base_vld && last_base) ? S_RDY : S_LD_BASE;
      S_RDY:      state_nxt = start ? S_LD_CONST : acc ? S_RD : S_RDY;
      S_RD:       state_nxt = (MUL_LAT > 1) ? S_WAIT : S_WR;
      S_WAIT:     state_nxt = (wcnt == WAIT_LAST) ? S_WR : S_WAIT;
      S_WR:       state_nxt = S_RDY;
      default:    state_nxt = S_IDLE;
    endcase
  end
  // registered outputs are decoded from the next state so they align with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      tf_valid     <= 1'b0;
      upd_ack      <= 1'b0;
      err_depth    <= 1'b0;
      init_done    <= 1'b0;
      busy         <= 1'b0;
      it_depth_cnt <= '0;
    end else begin
      state        <= state_nxt;
      wcnt         <= (state == S_WAIT) ? wcnt + 1'b1 : '0;
      ren_q        <= state_nxt == S_RD;
      tf_valid     <= state_nxt == S_RD;
      wen_q        <= state_nxt == S_WR;
      upd_ack      <= state_nxt == S_WR;
      err_depth    <= err;
      init_done    <= state_nxt inside {S_RDY, S_RD, S_WAIT, S_WR};
      busy         <= !(state_nxt inside {S_IDLE, S_RDY});
      it_depth_cnt <= acc ? upd_depth :
                      (ld_const || (ld_base && last_base)) ? '0 :
                      ld_base ? it_depth_cnt + 1'b1 : it_depth_cnt;
    end
  assert property (@(posedge clk) disable iff (rst) $onehot0(cmd))
    else $error("tf_gen_ctrl: more than one TF_gen strobe active");
`ifdef TF_GEN_CTRL_PERF_EN
  tf_sat_cnt #(.W(UPD_CNT_W)) u_upd_cnt (
    .clk(clk),
    .rst(rst),
    .clr(start && (state == S_IDLE || state == S_RDY)),
    .inc(upd_ack),
    .cnt(upd_cnt)
  );
`endif
endmodule

// File: tb/tb_tf_gen_ctrl.sv
// tb_tf_gen_ctrl: table-driven load checks plus scoreboarded update timing
`ifndef D_width
`define D_width 3
`endif
module tb_tf_gen_ctrl;
  localparam int IT_DEPTH = 3;
  localparam int MUL_LAT = 3;
  localparam int DW = `D_width;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, const_vld = 1'b0, base_vld = 1'b0, upd_req = 1'b0;
  logic [DW-1:0] upd_depth = '0;
  logic const_rdy, base_rdy, init_done, upd_ack, tf_valid, err_depth, busy;
  logic TF_init_const, TF_init_base, TF_ren, TF_wen;
  logic [DW-1:0] it_depth_cnt;
`ifdef TF_GEN_CTRL_PERF_EN
  logic [15:0] upd_cnt;
`endif
  logic [10:0] outs;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct { int s; int cv; int bv; int rq; int d; int o; int c; } vec_t;
  typedef struct { logic [DW-1:0] d; int ren_c; int ack_c; } sb_t;
  vec_t tv[7];
  sb_t sb[$];

  tf_gen_ctrl #(.IT_DEPTH(IT_DEPTH), .MUL_LAT(MUL_LAT), .D_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .const_vld(const_vld), .const_rdy(const_rdy),
    .base_vld(base_vld), .base_rdy(base_rdy),
    .init_done(init_done), .upd_req(upd_req), .upd_depth(upd_depth),
    .upd_ack(upd_ack), .tf_valid(tf_valid), .err_depth(err_depth), .busy(busy),
    .TF_init_const(TF_init_const), .TF_init_base(TF_init_base),
    .TF_ren(TF_ren), .TF_wen(TF_wen),
`ifdef TF_GEN_CTRL_PERF_EN
    .it_depth_cnt(it_depth_cnt), .upd_cnt(upd_cnt)
`else
    .it_depth_cnt(it_depth_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign outs = {const_rdy, base_rdy, TF_init_const, TF_init_base, TF_ren, TF_wen,
                 init_done, upd_ack, tf_valid, err_depth, busy};

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic drv(int s, int cv, int bv, int rq, int d);
    @(posedge clk);
    #1;
    start = s[0];
    const_vld = cv[0];
    base_vld = bv[0];
    upd_req = rq[0];
    upd_depth = d[DW-1:0];
  endtask

  task automatic load(int s);
    int n = 99;
    if (s != 0) drv(1, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drv(0, 1, 1, 0, 0);
      @(negedge clk);
      if (init_done) begin
        n = i;
        break;
      end
    end
    chk("load_time", n, 1 + IT_DEPTH);
    drv(0, 0, 0, 0, 0);
  endtask

  // request held high; the accepted depth differs from what is driven in between
  task automatic run_upd(int n);
    int p;
    int k;
    p = MUL_LAT + 2;
    for (int t = 0; t <= (n - 1) * p; t++) begin
      k = t / p;
      if (t % p == 0) begin
        drv(0, 0, 0, 1, 2 - k % 3);
        sb.push_back('{DW'(2 - k % 3), cyc + 1, cyc + 1 + MUL_LAT});
      end else drv(0, 0, 0, 1, (k + 1) % 3);
    end
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (TF_ren) begin
        chk("ren_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          chk("ren_cycle", cyc, sb[0].ren_c);
          chk("ren_depth", 32'(it_depth_cnt), 32'(sb[0].d));
          chk("ren_tf_valid", 32'(tf_valid), 1);
        end
      end
      if (upd_ack) begin
        chk("ack_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          chk("ack_cycle", cyc, sb[0].ack_c);
          chk("ack_depth", 32'(it_depth_cnt), 32'(sb[0].d));
          chk("ack_wen", 32'(TF_wen), 1);
          void'(sb.pop_front());
        end
      end else if (busy && init_done && sb.size() > 0)
        chk("depth_hold", 32'(it_depth_cnt), 32'(sb[0].d));
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{1, 1, 1, 1, 1, 11'b00000000000, 0};
    tv[1] = '{1, 1, 1, 1, 1, 11'b10100000001, 0};
    tv[2] = '{0, 1, 1, 1, 1, 11'b01010000001, 0};
    tv[3] = '{0, 1, 1, 1, 1, 11'b01010000001, 1};
    tv[4] = '{0, 1, 1, 1, 1, 11'b01010000001, 2};
    tv[5] = '{0, 0, 0, 0, 0, 11'b00000010000, 0};
    tv[6] = '{0, 0, 0, 0, 0, 11'b00000010000, 0};
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs), 0);
    chk("reset_cnt", 32'(it_depth_cnt), 0);
    rst = 1'b0;
    foreach (tv[i]) begin
      drv(tv[i].s, tv[i].cv, tv[i].bv, tv[i].rq, tv[i].d);
      @(negedge clk);
      chk("init_outs", 32'(outs), 32'(tv[i].o));
      chk("init_cnt", 32'(it_depth_cnt), 32'(tv[i].c));
    end
    run_upd(1);
    for (int b = 0; b < 2; b++) begin
      drv(0, 0, 0, 1, (b == 0) ? IT_DEPTH : (1 << DW) - 1);
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("bad_depth_err", 32'(outs), 32'(11'b00000010010));
      drv(0, 0, 0, 0, 0);
      @(negedge clk);
      chk("bad_depth_clear", 32'(outs), 32'(11'b00000010000));
    end
    run_upd(3);
    drv(1, 0, 0, 1, 1);
    drv(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("collision_reload", 32'(outs), 32'(11'b10000000001));
    load(0);
    drv(0, 0, 0, 1, 1);
    sb.push_back('{DW'(1), cyc + 1, cyc + 1 + MUL_LAT});
    drv(0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", 32'(outs), 0);
    chk("midrst_cnt", 32'(it_depth_cnt), 0);
    sb.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 1, 1);
      @(negedge clk);
      chk("postrst_ignore", 32'(outs), 0);
    end
    drv(0, 0, 0, 0, 0);
    load(1);
    run_upd(3);
`ifdef TF_GEN_CTRL_PERF_EN
    @(negedge clk);
    chk("upd_cnt", 32'(upd_cnt), 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
